// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle arithmetic/logic/compare ops and a sequential multiply.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier; otherwise opcode 111 reports illegal.
//
// state | meaning
// IDLE  | accepting requests; single-cycle ops complete on the accepting edge
// MUL   | shift-add multiply in progress, one partial product per cycle
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             borrow,
  output logic             equal,
  output logic             less,
  output logic             more,
  output logic             zero,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  logic             sc_accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic             op_borrow;
  logic             op_equal;
  logic             op_less;
  logic             op_more;
  logic             op_illegal;

  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    op_res     = '0;
    op_carry   = 1'b0;
    op_borrow  = 1'b0;
    op_equal   = 1'b0;
    op_less    = 1'b0;
    op_more    = 1'b0;
    op_illegal = 1'b0;
    case (opcode)
      OP_ADD: begin
        op_res   = sum[WIDTH-1:0];
        op_carry = sum[WIDTH];
      end
      OP_SUB: begin
        op_res    = a - b;
        op_borrow = (a < b);
      end
      OP_XOR:  op_res = a ^ b;
      OP_AND:  op_res = a & b;
      OP_NOR:  op_res = ~(a | b);
      OP_NAND: op_res = ~(a & b);
      OP_CMP: begin
        op_equal = (a == b);
        op_less  = (a < b);
        op_more  = (a > b);
      end
`ifdef ALU_SEQ_MUL_EN
      default: ;
`else
      default: op_illegal = 1'b1;
`endif
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic               mul_start;
  logic               mul_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && opcode == OP_MUL) begin
          mul_start = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        if (cnt == '0) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign sc_accept = in_valid && in_ready && !mul_start;

  // cnt counts remaining partial products; the step taken at cnt==0 is the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (mul_start) begin
      cnt    <= CW'(WIDTH - 1);
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (state == MUL) begin
      cnt    <= cnt - CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end
  end
`else
  assign in_ready  = !out_valid || out_ready;
  assign sc_accept = in_valid && in_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      equal     <= 1'b0;
      less      <= 1'b0;
      more      <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (sc_accept) begin
      out_valid <= 1'b1;
      result    <= op_res;
      result_hi <= '0;
      carry     <= op_carry;
      borrow    <= op_borrow;
      equal     <= op_equal;
      less      <= op_less;
      more      <= op_more;
      zero      <= (op_res == '0);
      illegal   <= op_illegal;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= acc_nxt[WIDTH-1:0];
      result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
      carry     <= 1'b0;
      borrow    <= 1'b0;
      equal     <= 1'b0;
      less      <= 1'b0;
      more      <= 1'b0;
      zero      <= (acc_nxt == '0);
      illegal   <= 1'b0;
    end
`endif
    else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); covers both ALU_SEQ_MUL_EN builds.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       carry, borrow, equal, less, more, zero, illegal;
  logic [6:0] flags;

  int errors = 0;
  int checks = 0;

  assign flags = {carry, borrow, equal, less, more, zero, illegal};

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .borrow    (borrow),
    .equal     (equal),
    .less      (less),
    .more      (more),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
    in_valid = v;
    opcode   = op;
    a        = va;
    b        = vb;
  endtask

  // flags order: carry borrow equal less more zero illegal
  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, result, result_hi, flags} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b res=%h hi=%h flags=%b, expected all zero", out_valid, result, result_hi, flags);
    end
    tick;
    tick;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 8'd200, 8'd100);
    tick;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    checks++;
    if ({out_valid, result, result_hi, flags} !== {1'b1, 8'h2C, 8'h00, 7'b1000000}) begin
      errors++;
      $display("FAIL add_200_100: got ov=%b res=%h hi=%h flags=%b, expected ov=1 res=2c hi=00 flags=1000000", out_valid, result, result_hi, flags);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_consumed: got ov=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [8] = '{3'b001, 3'b110, 3'b110, 3'b110, 3'b100, 3'b101, 3'b000, 3'b011};
    logic [7:0] va  [8] = '{8'd5,  8'd9,  8'd3,  8'd8,  8'hF0, 8'hFF, 8'hFF, 8'hAC};
    logic [7:0] vb  [8] = '{8'd7,  8'd9,  8'd8,  8'd3,  8'h0F, 8'hFF, 8'h01, 8'h0F};
    logic [7:0] er  [8] = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C};
    logic [6:0] ef  [8] = '{7'b0100000, 7'b0010010, 7'b0001010, 7'b0000110,
                            7'b0000010, 7'b0000010, 7'b1000010, 7'b0000000};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ops[i], va[i], vb[i]);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick;
      checks++;
      if ({out_valid, result, result_hi, flags} !== {1'b1, er[i], 8'h00, ef[i]}) begin
        errors++;
        $display("FAIL b2b_op[%0d]: got ov=%b res=%h hi=%h flags=%b, expected ov=1 res=%h hi=00 flags=%b",
                 i, out_valid, result, result_hi, flags, er[i], ef[i]);
      end
    end
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    tick;
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 8'hF0, 8'h3C);
    tick;
    drive(1'b1, 3'b000, 8'd1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, result, result_hi, flags} !== {1'b1, 1'b0, 8'hCC, 8'h00, 7'b0000000}) begin
        errors++;
        $display("FAIL hold[%0d]: got ov=%b rdy=%b res=%h hi=%h flags=%b, expected ov=1 rdy=0 res=cc hi=00 flags=0000000",
                 i, out_valid, in_ready, result, result_hi, flags);
      end
      tick;
    end
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got ov=%b expected 0", out_valid);
    end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_multiply;
    logic [7:0] va [2] = '{8'd255, 8'd13};
    logic [7:0] vb [2] = '{8'd255, 8'd11};
    logic [15:0] ep [2] = '{16'hFE01, 16'h008F};
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 3'b111, va[t], vb[t]);
      tick;
      // second run keeps in_valid high with an add to show it is ignored during MUL
      if (t == 0) drive(1'b0, 3'b000, 8'd0, 8'd0);
      else        drive(1'b1, 3'b000, 8'd1, 8'd1);
      for (int c = 0; c < 8; c++) begin
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
          errors++;
          $display("FAIL mul_busy[%0d][%0d]: got rdy=%b ov=%b, expected 0 0", t, c, in_ready, out_valid);
        end
        tick;
      end
      checks++;
      if ({out_valid, result_hi, result, flags} !== {1'b1, ep[t], 7'b0000000}) begin
        errors++;
        $display("FAIL mul_result[%0d]: got ov=%b hi=%h res=%h flags=%b, expected ov=1 product=%h flags=0000000",
                 t, out_valid, result_hi, result, flags, ep[t]);
      end
      drive(1'b0, 3'b000, 8'd0, 8'd0);
      tick;
    end
  endtask

  task automatic test_reset_abort;
    out_ready = 1'b1;
    drive(1'b1, 3'b111, 8'd255, 8'd255);
    tick;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, result, result_hi, flags} !== 24'h0) begin
      errors++;
      $display("FAIL abort_outputs: got ov=%b res=%h hi=%h flags=%b, expected all zero", out_valid, result, result_hi, flags);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_ready: got %b expected 1", in_ready);
    end
    drive(1'b1, 3'b000, 8'd1, 8'd1);
    tick;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    checks++;
    if ({out_valid, result, result_hi, flags} !== {1'b1, 8'h02, 8'h00, 7'b0000000}) begin
      errors++;
      $display("FAIL abort_add: got ov=%b res=%h hi=%h flags=%b, expected ov=1 res=02 hi=00 flags=0000000", out_valid, result, result_hi, flags);
    end
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++;
      if ({out_valid, result, result_hi} !== {1'b0, 8'h02, 8'h00}) begin
        errors++;
        $display("FAIL abort_trace[%0d]: got ov=%b res=%h hi=%h, expected ov=0 res=02 hi=00", c, out_valid, result, result_hi);
      end
    end
  endtask
`else
  task automatic test_multiply;
    out_ready = 1'b1;
    drive(1'b1, 3'b111, 8'd255, 8'd255);
    tick;
    drive(1'b1, 3'b000, 8'd3, 8'd4);
    checks++;
    if ({out_valid, result, result_hi, flags} !== {1'b1, 8'h00, 8'h00, 7'b0000011}) begin
      errors++;
      $display("FAIL mul_illegal: got ov=%b res=%h hi=%h flags=%b, expected ov=1 res=00 hi=00 flags=0000011", out_valid, result, result_hi, flags);
    end
    tick;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'h07, 7'b0000000}) begin
      errors++;
      $display("FAIL after_illegal: got ov=%b res=%h flags=%b, expected ov=1 res=07 flags=0000000", out_valid, result, flags);
    end
    tick;
  endtask

  task automatic test_reset_abort;
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 8'd9, 8'd9);
    tick;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, result, result_hi, flags} !== 24'h0) begin
      errors++;
      $display("FAIL abort_outputs: got ov=%b res=%h hi=%h flags=%b, expected all zero", out_valid, result, result_hi, flags);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_ready: got %b expected 1", in_ready);
    end
    drive(1'b1, 3'b000, 8'd1, 8'd1);
    tick;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    checks++;
    if ({out_valid, result, result_hi, flags} !== {1'b1, 8'h02, 8'h00, 7'b0000000}) begin
      errors++;
      $display("FAIL abort_add: got ov=%b res=%h hi=%h flags=%b, expected ov=1 res=02 hi=00 flags=0000000", out_valid, result, result_hi, flags);
    end
    tick;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 8'd0, 8'd0);
    test_reset;
    test_add;
    test_back_to_back;
    test_hold;
    test_multiply;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  request valid; a, b and opcode are sampled on acceptance.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a, b  input  WIDTH  unsigned operands.
REQ-007 opcode  input  3  000 add, 001 sub, 010 xor, 011 and, 100 nor, 101 nand, 110 compare, 111 multiply.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 result  output  WIDTH  primary result, or low half of the product.
REQ-011 result_hi  output  WIDTH  high half of the product; 0 for every other opcode.
REQ-012 carry, borrow, equal, less, more, zero, illegal  output  1 each  status flags.

Function
REQ-013 Handshake: a request is accepted at a rising edge with in_valid=1 and in_ready=1, and a result is consumed at a rising edge with out_valid=1 and out_ready=1.
REQ-014 in_ready = (state==IDLE) && (!out_valid || out_ready), so back-to-back single-cycle ops sustain one op per cycle.
REQ-015 State machine states: IDLE, MUL. IDLE->MUL on acceptance of opcode 111; MUL->IDLE after WIDTH steps; all other accepts stay in IDLE.
REQ-016 Single-cycle ops: accepted at edge N, result, flags and out_valid=1 are registered at edge N.
REQ-017 add: {carry,result}=a+b at WIDTH+1 bits; borrow=0.
REQ-018 sub: result=a-b mod 2^WIDTH; borrow=1 iff a<b; carry=0.
REQ-019 xor/and/nor/nand: bitwise; carry=borrow=0.
REQ-020 compare: result=0; exactly one of equal, less, more is 1 (unsigned a vs b).
REQ-021 equal, less and more are 0 for every opcode except 110, and carry/borrow are 0 except where REQ-017/018 set them; no flag holds a stale value from a previous op.
REQ-022 zero=1 iff {result_hi,result}==0, valid for all ops.
REQ-023 multiply: shift-add, one partial product per cycle; accepted at edge N, out_valid=1 at edge N+WIDTH; {result_hi,result}=a*b, exact 2*WIDTH bits.
REQ-024 While out_valid=1 and out_ready=0, result, result_hi, the flags and out_valid hold stable.
REQ-025 out_valid clears on consumption unless a new request is accepted at the same edge, in which case the new result replaces the old one.
REQ-026 in_ready=0 throughout MUL; in_valid is ignored in that state.
REQ-027 illegal=0 for all opcodes except as specified in REQ-031.

Reset
REQ-028 rst=1 forces state IDLE, out_valid=0, result=0, result_hi=0, and all flags to 0 immediately, independent of clk.
REQ-029 Reset during MUL aborts the multiply with no output; in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-030 Macro ALU_SEQ_MUL_EN defined: multiply is implemented per REQ-015 and REQ-023.
REQ-031 Macro ALU_SEQ_MUL_EN undefined: no MUL state or multiplier logic; opcode 111 completes in one cycle with result=0, result_hi=0, illegal=1, zero=1, and all other flags 0.

Verification (WIDTH=8)
REQ-032 add a=200, b=100 -> next edge out_valid=1, result=0x2C, carry=1, zero=0.
REQ-033 sub a=5, b=7, then compare a=9, b=9 on consecutive cycles with out_ready=1 -> result=0xFE with borrow=1, then result=0 with equal=1, less=0, more=0, borrow=0.
REQ-034 multiply a=255, b=255 (MUL_EN) -> in_ready=0 for 8 cycles, out_valid at edge N+8, result_hi=0xFE, result=0x01; without the macro -> illegal=1, result=0.
REQ-035 out_ready=0 for 5 cycles after an xor 0xF0^0x3C -> result=0xCC held stable, in_ready=0, and out_valid drops after out_ready=1.
REQ-036 rst pulse 3 cycles into a multiply -> outputs 0 immediately; a following add 1+1 gives result=2 with no trace of the aborted product.
